// File: rtl/mem_master_if.sv
// Core request/response handshake plus the MMU-side memory bus, bundled so
// the initiator and whatever sits on the other side share one port list.
interface mem_master_if;
  // core request channel
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [1:0]  REQ_SIZE;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  // core response channel
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_FAULT;
  // memory bus toward the MMU
  logic [31:0] ADDR;
  logic        N_OE;
  logic        N_WE;
  logic [31:0] BUS_WDATA;
  logic [31:0] BUS_RDATA;

  modport master (
    input  REQ_VALID, REQ_WE, REQ_SIZE, REQ_ADDR, REQ_WDATA, BUS_RDATA,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_FAULT,
    output ADDR, N_OE, N_WE, BUS_WDATA
  );

  modport slave (
    output REQ_VALID, REQ_WE, REQ_SIZE, REQ_ADDR, REQ_WDATA, BUS_RDATA,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_FAULT,
    input  ADDR, N_OE, N_WE, BUS_WDATA
  );
endinterface

// File: rtl/mem_master.sv
// Memory bus initiator: byte/half/word loads and stores with setup, pulse and
// hold phasing of the strobes. The bus has no byte enables, so sub-word stores
// read the word first and write back the merged value. Every output is a
// register fed from the next-state logic, so strobes follow the state exactly.
module mem_master #(
  parameter int RD_WAIT   = 1,
  parameter int WE_CYCLES = 1,
  parameter int ADDR_BITS = 17
) (
  input  logic          CLK,
  input  logic          N_RST,
  mem_master_if.master  bus
);

  typedef enum logic [2:0] {IDLE, RD, WSETUP, WPULSE, WHOLD, DONE} state_t;

  // last counter value of the read strobe and of the write pulse
  localparam logic [7:0] RD_LAST = 8'(RD_WAIT);
  localparam logic [7:0] WE_LAST = 8'(WE_CYCLES - 1);

  state_t      r_state, w_state_next;
  logic [7:0]  r_cnt, w_cnt_next;
  logic        r_we, w_we_next;
  logic [1:0]  r_size, w_size_next;
  logic [1:0]  r_lane, w_lane_next;
  logic [31:0] r_wdata, w_wdata_next;
  logic        r_ready, w_ready_next;
  logic        r_rsp_valid, w_rsp_valid_next;
  logic [31:0] r_rsp_rdata, w_rsp_rdata_next;
  logic        r_rsp_fault, w_rsp_fault_next;
  logic [31:0] r_addr, w_addr_next;
  logic        r_n_oe, w_n_oe_next;
  logic        r_n_we, w_n_we_next;
  logic [31:0] r_bus_wdata, w_bus_wdata_next;

  logic        w_accept;
  logic        w_fault;
  logic [4:0]  w_shift;
  logic [31:0] w_rd_shifted;
  logic [31:0] w_load;
  logic [31:0] w_size_mask;
  logic [31:0] w_merge;

  assign w_accept = (r_state == IDLE) && r_ready && bus.REQ_VALID;

  // misaligned, illegal size or any address bit above the legal window
  assign w_fault = (bus.REQ_SIZE == 2'd3) ||
                   ((bus.REQ_SIZE == 2'd1) && bus.REQ_ADDR[0]) ||
                   ((bus.REQ_SIZE == 2'd2) && (bus.REQ_ADDR[1:0] != 2'b00)) ||
                   ((bus.REQ_ADDR >> ADDR_BITS) != 32'd0);

  // little-endian lane position of the latched request within the bus word
  assign w_shift      = {r_lane, 3'b000};
  assign w_rd_shifted = bus.BUS_RDATA >> w_shift;
  assign w_size_mask  = (r_size == 2'd0) ? 32'h0000_00FF :
                        (r_size == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  assign w_load       = w_rd_shifted & w_size_mask;
  assign w_merge      = (bus.BUS_RDATA & ~(w_size_mask << w_shift)) |
                        ((r_wdata & w_size_mask) << w_shift);

  // next state, request latching and registered output values
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_we_next        = r_we;
    w_size_next      = r_size;
    w_lane_next      = r_lane;
    w_wdata_next     = r_wdata;
    w_rsp_rdata_next = r_rsp_rdata;
    w_rsp_fault_next = r_rsp_fault;
    w_addr_next      = r_addr;
    w_bus_wdata_next = r_bus_wdata;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_we_next        = bus.REQ_WE;
          w_size_next      = bus.REQ_SIZE;
          w_lane_next      = bus.REQ_ADDR[1:0];
          w_wdata_next     = bus.REQ_WDATA;
          w_rsp_rdata_next = 32'd0;
          w_cnt_next       = 8'd0;
          if (w_fault) begin
            // bus registers untouched: a fault never reaches the bus
            w_rsp_fault_next = 1'b1;
            w_state_next     = DONE;
          end else begin
            w_rsp_fault_next = 1'b0;
            w_addr_next      = {bus.REQ_ADDR[31:2], 2'b00};
            if (!bus.REQ_WE || (bus.REQ_SIZE != 2'd2)) begin
              w_state_next = RD;
            end else begin
              w_bus_wdata_next = bus.REQ_WDATA;
              w_state_next     = WSETUP;
            end
          end
        end
      end
      RD: begin
        if (r_cnt == RD_LAST) begin
          if (!r_we) begin
            w_rsp_rdata_next = w_load;
            w_state_next     = DONE;
          end else begin
            w_bus_wdata_next = w_merge;
            w_state_next     = WSETUP;
          end
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      WSETUP: begin
        w_cnt_next   = 8'd0;
        w_state_next = WPULSE;
      end
      WPULSE: begin
        if (r_cnt == WE_LAST) begin
          w_state_next = WHOLD;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      WHOLD:   w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase

    // strobes and handshake are decoded from the state being entered
    w_n_oe_next      = (w_state_next != RD);
    w_n_we_next      = (w_state_next != WPULSE);
    w_rsp_valid_next = (w_state_next == DONE);
    w_ready_next     = (w_state_next == IDLE);
  end

  // state and output registers; reset drops any in-flight request
  always_ff @(posedge CLK) begin
    if (N_RST) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_we        <= 1'b0;
      r_size      <= 2'd0;
      r_lane      <= 2'd0;
      r_wdata     <= 32'd0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_fault <= 1'b0;
      r_addr      <= 32'd0;
      r_n_oe      <= 1'b1;
      r_n_we      <= 1'b1;
      r_bus_wdata <= 32'd0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_we        <= w_we_next;
      r_size      <= w_size_next;
      r_lane      <= w_lane_next;
      r_wdata     <= w_wdata_next;
      r_ready     <= w_ready_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_rdata <= w_rsp_rdata_next;
      r_rsp_fault <= w_rsp_fault_next;
      r_addr      <= w_addr_next;
      r_n_oe      <= w_n_oe_next;
      r_n_we      <= w_n_we_next;
      r_bus_wdata <= w_bus_wdata_next;
    end
  end

  assign bus.REQ_READY = r_ready;
  assign bus.RSP_VALID = r_rsp_valid;
  assign bus.RSP_RDATA = r_rsp_rdata;
  assign bus.RSP_FAULT = r_rsp_fault;
  assign bus.ADDR      = r_addr;
  assign bus.N_OE      = r_n_oe;
  assign bus.N_WE      = r_n_we;
  assign bus.BUS_WDATA = r_bus_wdata;

endmodule

// File: tb/tb_mem_master.sv
// Bench for mem_master: instance 0 uses default timing for the directed cases,
// instance 1 uses RD_WAIT=3, WE_CYCLES=2 for random back-to-back traffic.
// Expected responses come from a byte-lane reference memory and are queued at
// accept time; a negedge monitor pops them and also watches the bus strobes.
`timescale 1ns/1ps
module tb_mem_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // per-instance bench-side copies of the interface signals
  logic        req_valid [2];
  logic        req_we    [2];
  logic [1:0]  req_size  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [31:0] bus_rdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_fault [2];
  logic [31:0] addr      [2];
  logic        n_oe      [2];
  logic        n_we      [2];
  logic [31:0] bus_wdata [2];

  int rdw [2] = '{1, 3};
  int wec [2] = '{1, 2};

  mem_master_if ifs [2] ();

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      assign ifs[gi].REQ_VALID = req_valid[gi];
      assign ifs[gi].REQ_WE    = req_we[gi];
      assign ifs[gi].REQ_SIZE  = req_size[gi];
      assign ifs[gi].REQ_ADDR  = req_addr[gi];
      assign ifs[gi].REQ_WDATA = req_wdata[gi];
      assign ifs[gi].BUS_RDATA = bus_rdata[gi];
      assign req_ready[gi] = ifs[gi].REQ_READY;
      assign rsp_valid[gi] = ifs[gi].RSP_VALID;
      assign rsp_rdata[gi] = ifs[gi].RSP_RDATA;
      assign rsp_fault[gi] = ifs[gi].RSP_FAULT;
      assign addr[gi]      = ifs[gi].ADDR;
      assign n_oe[gi]      = ifs[gi].N_OE;
      assign n_we[gi]      = ifs[gi].N_WE;
      assign bus_wdata[gi] = ifs[gi].BUS_WDATA;

      mem_master #(
        .RD_WAIT   ((gi == 0) ? 1 : 3),
        .WE_CYCLES ((gi == 0) ? 1 : 2),
        .ADDR_BITS (17)
      ) u_dut (
        .CLK   (clk),
        .N_RST (rst),
        .bus   (ifs[gi])
      );
    end
  endgenerate

  typedef struct {
    int          d;
    logic [31:0] rdata;
    logic        fault;
    int          rsp_cyc;
    logic        is_store;
    int          key;
    logic [31:0] word;
    int          we_cyc;
    int          strobes;
    logic [31:0] baddr;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] bus_mem [int];
  logic [31:0] ref_mem [int];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int key_of(input int d, input logic [31:0] a);
    return (d << 24) | int'(a[16:2]);
  endfunction

  // memory behind each bus: data returned at negedge, written while N_WE low
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst && (n_we[d] === 1'b0)) bus_mem[key_of(d, addr[d])] = bus_wdata[d];
      if (bus_mem.exists(key_of(d, addr[d]))) bus_rdata[d] <= bus_mem[key_of(d, addr[d])];
      else bus_rdata[d] <= 32'd0;
    end
  end

  // bus and response monitor
  int oe_len [2] = '{0, 0};
  int we_len [2] = '{0, 0};
  int we_start [2] = '{-1, -1};
  int strobe_cnt [2] = '{0, 0};
  logic [31:0] prev_addr [2];
  logic [31:0] prev_wd [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        oe_len[d] = 0;
        we_len[d] = 0;
      end else begin
        check($sformatf("strobe_excl%0d", d), 32'(n_oe[d] | n_we[d]), 32'd1);
        if (n_oe[d] === 1'b0) begin
          oe_len[d]++;
        end else if (oe_len[d] > 0) begin
          check($sformatf("oe_len%0d", d), 32'(oe_len[d]), 32'(rdw[d] + 1));
          oe_len[d] = 0;
        end
        if (n_we[d] === 1'b0) begin
          if (we_len[d] == 0) begin
            we_start[d] = cyc;
          end else begin
            check($sformatf("we_addr_stable%0d", d), addr[d], prev_addr[d]);
            check($sformatf("we_data_stable%0d", d), bus_wdata[d], prev_wd[d]);
          end
          we_len[d]++;
          prev_addr[d] = addr[d];
          prev_wd[d]   = bus_wdata[d];
        end else if (we_len[d] > 0) begin
          check($sformatf("we_len%0d", d), 32'(we_len[d]), 32'(wec[d]));
          we_len[d] = 0;
        end
        if ((n_oe[d] === 1'b0) || (n_we[d] === 1'b0)) begin
          strobe_cnt[d]++;
          if (sb.size() > 0) check($sformatf("bus_addr%0d", d), addr[d], sb[0].baddr);
        end
        if (rsp_valid[d] === 1'b1) begin
          if ((sb.size() == 0) || (sb[0].d != d)) begin
            check($sformatf("rsp_unexpected%0d", d), 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            $display("rsp dut%0d cyc=%0d rdata=%h fault=%0b", d, cyc, rsp_rdata[d], rsp_fault[d]);
            check("rsp_rdata", rsp_rdata[d], e.rdata);
            check("rsp_fault", 32'(rsp_fault[d]), 32'(e.fault));
            check("rsp_cycle", 32'(cyc), 32'(e.rsp_cyc));
            if (e.is_store) begin
              check("bus_word", bus_mem.exists(e.key) ? bus_mem[e.key] : 32'd0, e.word);
              check("we_cycle", 32'(we_start[d]), 32'(e.we_cyc));
            end
            if (e.fault) check("fault_no_strobe", 32'(strobe_cnt[d]), 32'(e.strobes));
          end
        end
      end
    end
  end

  // drive one request, predict its outcome, return at negedge after accept
  task automatic issue(input int d, input logic we, input logic [1:0] size,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] old, nw, r;
    int          nb, lane, lat, we_off, n;
    e.d = d; e.rdata = 32'd0; e.is_store = 1'b0; e.key = 0; e.word = 32'd0;
    e.baddr = {a[31:2], 2'b00};
    e.fault = (size == 2'd3) || ((size == 2'd1) && a[0]) ||
              ((size == 2'd2) && (a[1:0] != 2'b00)) || ((a >> 17) != 32'd0);
    nb = (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
    lane = int'(a[1:0]);
    we_off = -1;
    lat = 1;
    if (!e.fault) begin
      e.key = key_of(d, a);
      old = ref_mem.exists(e.key) ? ref_mem[e.key] : 32'd0;
      if (!we) begin
        r = 32'd0;
        for (int j = 0; j < nb; j++) r[8*j +: 8] = old[8*(lane + j) +: 8];
        e.rdata = r;
        lat = rdw[d] + 2;
      end else begin
        nw = old;
        for (int j = 0; j < nb; j++) nw[8*(lane + j) +: 8] = wd[8*j +: 8];
        ref_mem[e.key] = nw;
        e.is_store = 1'b1;
        e.word = nw;
        we_off = (size == 2'd2) ? 2 : rdw[d] + 3;
        lat = we_off + wec[d] + 1;
      end
    end
    req_we[d] = we; req_size[d] = size; req_addr[d] = a; req_wdata[d] = wd;
    req_valid[d] = 1'b1;
    n = 0;
    while ((req_ready[d] !== 1'b1) && (n < 60)) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(req_ready[d]), 32'd1);
    e.rsp_cyc = cyc + lat;
    e.we_cyc  = e.is_store ? cyc + we_off : -1;
    e.strobes = strobe_cnt[d];
    sb.push_back(e);
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          n;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'd0;
      req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_n_oe", 32'(n_oe[d]), 32'd1);
      check("rst_n_we", 32'(n_we[d]), 32'd1);
      check("rst_addr", addr[d], 32'd0);
      check("rst_wdata", bus_wdata[d], 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      check("rst_rsp_rdata", rsp_rdata[d], 32'd0);
      check("rst_rsp_fault", 32'(rsp_fault[d]), 32'd0);
      check("rst_ready", 32'(req_ready[d]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // directed traffic on the default-timing instance
    issue(0, 1'b1, 2'd2, 32'h0000_0010, 32'hDEAD_BEEF);
    issue(0, 1'b0, 2'd2, 32'h0000_0010, 32'h0);
    issue(0, 1'b1, 2'd2, 32'h0000_0010, 32'h1122_3344);
    issue(0, 1'b1, 2'd0, 32'h0000_0013, 32'h0000_00A5);
    issue(0, 1'b0, 2'd0, 32'h0000_0013, 32'h0);
    bus_mem[key_of(0, 32'h0001_0000)] = 32'hCAFE_1234;
    ref_mem[key_of(0, 32'h0001_0000)] = 32'hCAFE_1234;
    issue(0, 1'b0, 2'd1, 32'h0001_0002, 32'h0);
    issue(0, 1'b0, 2'd1, 32'h0000_0012, 32'h0);
    issue(0, 1'b1, 2'd1, 32'h0000_0012, 32'h0000_BEEF);
    issue(0, 1'b0, 2'd2, 32'h0000_0010, 32'h0);
    issue(0, 1'b0, 2'd2, 32'h0000_0002, 32'h0);
    issue(0, 1'b1, 2'd1, 32'h0000_0001, 32'h1234);
    issue(0, 1'b0, 2'd3, 32'h0000_0004, 32'h0);
    issue(0, 1'b1, 2'd2, 32'h0002_0000, 32'h5555_AAAA);
    drain();

    // reset while N_WE is low drops the store without a response
    issue(0, 1'b1, 2'd2, 32'h0000_0020, 32'h1234_5678);
    n = 0;
    while ((n_we[0] !== 1'b0) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    check("reach_wpulse", 32'(n_we[0]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    check("rst_mid_n_we", 32'(n_we[0]), 32'd1);
    check("rst_mid_ready", 32'(req_ready[0]), 32'd0);
    check("rst_mid_rsp", 32'(rsp_valid[0]), 32'd0);
    @(negedge clk);
    check("rst_mid_rsp2", 32'(rsp_valid[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    issue(0, 1'b0, 2'd2, 32'h0000_0010, 32'h0);
    drain();

    // random back-to-back traffic on the slow-timing instance
    for (int i = 0; i < 150; i++) begin
      n  = $urandom_range(0, 15);
      sz = (n < 14) ? 2'(n % 3) : 2'd3;
      a  = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 19) == 0) a = a | (32'd1 << $urandom_range(17, 31));
      issue(1, 1'($urandom_range(0, 1)), sz, a, $urandom);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
